// File: rtl/alu_pkg.sv
// Shared types for the ALU result FIFO: function code, result entry and occupancy states.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  typedef logic [2:0] alu_f_t;

  typedef struct packed {
    alu_f_t                 f;
    logic [ALU_WIDTH-1:0]   y;
    logic                   zero;
    logic                   carry;
    logic                   overflow;
  } alu_result_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fifo_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/alu_result_mem.sv
// Result storage: DEPTH x alu_result_t, one synchronous write port, one asynchronous read port.
module alu_result_mem
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  alu_result_t   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output alu_result_t   o_rdata
);

  alu_result_t r_mem [DEPTH];

  // NOTE: no reset on the array; the top masks the head word whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// Elastic buffer for ALU results with occupancy FSM, saturating pop counter and optional
// sticky carry/overflow flags (enabled by defining ALU_RESULT_FIFO_STICKY_EN). WIDTH must equal alu_pkg::ALU_WIDTH.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_f,
  input  logic [WIDTH-1:0]           in_y,
  input  logic                       in_zero,
  input  logic                       in_carry,
  input  logic                       in_overflow,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_f,
  output logic [WIDTH-1:0]           out_y,
  output logic                       out_zero,
  output logic                       out_carry,
  output logic                       out_overflow,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic                       clear_sticky,
  output logic                       sticky_carry,
  output logic                       sticky_overflow,
  output logic [15:0]                pop_total
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [15:0]      r_pop_total;
  fifo_state_t      r_state;
  fifo_state_t      w_state_next;
  logic             w_push;
  logic             w_pop;
  alu_result_t      w_wr_entry;
  alu_result_t      w_head;

  // Handshake depends only on the registered count, so out_ready never reaches in_ready.
  assign in_ready  = (r_count < CNT_FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready && !reset;
  assign w_pop     = out_valid && out_ready && !reset;

  assign w_wr_entry = '{f: in_f, y: in_y, zero: in_zero, carry: in_carry, overflow: in_overflow};

  alu_result_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_entry),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pop_total <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_pop) r_pop_total <= sat_inc16(r_pop_total);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= EMPTY;
    else       r_state <= w_state_next;
  end

  // NOTE: next-state defaults to the current state before the case, so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      EMPTY: begin
        if (w_push) w_state_next = PARTIAL;
      end
      PARTIAL: begin
        if (w_push && !w_pop && (r_count == CNT_FULL - CNT_ONE))
          w_state_next = FULL;
        else if (w_pop && !w_push && (r_count == CNT_ONE))
          w_state_next = EMPTY;
      end
      FULL: begin
        if (w_pop) w_state_next = PARTIAL;
      end
      default: w_state_next = EMPTY;
    endcase
  end

  // Head fields read as zero while empty, which also gives the all-zero reset value.
  assign out_f        = out_valid ? w_head.f        : '0;
  assign out_y        = out_valid ? w_head.y        : '0;
  assign out_zero     = out_valid && w_head.zero;
  assign out_carry    = out_valid && w_head.carry;
  assign out_overflow = out_valid && w_head.overflow;
  assign count        = r_count;
  assign pop_total    = r_pop_total;

`ifdef ALU_RESULT_FIFO_STICKY_EN
  logic r_sticky_carry;
  logic r_sticky_overflow;

  // A set in the same cycle as clear_sticky takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sticky_carry    <= 1'b0;
      r_sticky_overflow <= 1'b0;
    end else begin
      r_sticky_carry    <= (w_push && in_carry)    || (r_sticky_carry    && !clear_sticky);
      r_sticky_overflow <= (w_push && in_overflow) || (r_sticky_overflow && !clear_sticky);
    end
  end

  assign sticky_carry    = r_sticky_carry;
  assign sticky_overflow = r_sticky_overflow;
`else
  logic w_unused_clear_sticky;
  assign w_unused_clear_sticky = clear_sticky;
  assign sticky_carry          = 1'b0;
  assign sticky_overflow       = 1'b0;
`endif

endmodule
